reg16_port_arbiter: RTL
=======================

// Module: reg16_port_arbiter
// PURPOSE
//   Two-master Avalon-MM arbiter in front of a single-port bank of 16-bit registers.
//   Ports A and B both address the shared bank through it.
//   Round-robin grant; losers are stalled with waitrequest.
//   Drives the bank's address/byteenable/writedata/write strobe; reads return with latency 1.
// PARAMETERS
//   ADDR_W    2   register-bank word address width (2**ADDR_W registers)
//   LOCK_MAX  16  max cycles a lock may hold the grant (ARB_LOCK_EN only), >=1
// PORTS
//   clock              in   1       single clock, all logic on rising edge
//   reset              in   1       synchronous, active-high
//   {a,b}_chipselect   in   1       per-port Avalon select
//   {a,b}_read         in   1       read request
//   {a,b}_write        in   1       write request
//   {a,b}_address      in   ADDR_W  word address
//   {a,b}_byteenable   in   2       byte lanes for writes
//   {a,b}_writedata    in   16      write data
//   {a,b}_waitrequest  out  1       stall; master holds request while high
//   {a,b}_readdata     out  16      registered read data
//   {a,b}_readdatavalid out 1       one-cycle pulse, readdata valid
//   reg_address        out  ADDR_W  to register bank
//   reg_byteenable     out  2       to bank; 2'b00 when no write
//   reg_writedata      out  16      to bank
//   reg_write          out  1       bank write strobe
//   reg_readdata       in   16      bank read data, combinational from reg_address
// BEHAVIOUR
// - Request and precedence
//   - req_x = x_chipselect & (x_read | x_write).
//   - read and write both high: write is performed, read ignored, no readdatavalid.
// - Grant (combinational)
//   - Only one port requests: that port is granted.
//   - Both request: grant goes to the port that is not last_grant.
//   - One access accepted per cycle.
//   - x_waitrequest = req_x & ~grant_x. It is forced to req_x while reset is high.
// - Granted write (same cycle)
//   - reg_write=1; reg_address, reg_byteenable, reg_writedata muxed from the winner.
//   - The bank commits at the next edge.
// - Granted read
//   - reg_address muxed from the winner; reg_write=0; reg_byteenable=0.
//   - reg_readdata is captured into x_readdata at the edge.
//   - x_readdatavalid=1 for exactly the next cycle.
//   - x_readdata holds its value until the next read of that port.
// - Ordering: a write granted in cycle N is visible to any read granted in cycle N+1 or later.
// - last_grant updates at every edge where a grant occurs.
//   Back-to-back contention therefore alternates A,B,A,B.
// - Reset
//   - Values: readdata=0, readdatavalid=0, last_grant=B (A wins first tie), state IDLE, lock counter 0.
//   - A read accepted in the cycle reset rises produces no readdatavalid.
// - Idle outputs: no request -> reg_write=0, reg_byteenable=0, reg_address=0, reg_writedata=0.
// CONFIGURATION
//   Macro ARB_LOCK_EN.
//   - Defined:
//     - Adds inputs a_lock, b_lock (1 bit each).
//     - FSM states: IDLE, LOCK_A, LOCK_B.
//     - IDLE->LOCK_x when x is granted with x_lock=1.
//     - In LOCK_x only x may be granted; the other port waits.
//     - Lock counter increments every cycle in LOCK_x.
//     - LOCK_x->IDLE when x_lock=0, or when the counter reaches LOCK_MAX (forced release).
//       On exit: last_grant=x, counter cleared.
//     - After a forced release, x cannot re-lock until x_lock has been low for >=1 cycle.
//     - Reset in any state -> IDLE.
//   - Undefined: no lock ports; FSM stays IDLE; LOCK_MAX unused; behaviour exactly as above.
// TESTING
// 1. Single writer, then reader
//    - A writes 16'hBEEF, addr 1, be 2'b11; B reads addr 1 the next cycle.
//    - Expect: no waitrequest on either port; b_readdatavalid high one cycle later; b_readdata=16'hBEEF.
// 2. Contention
//    - A and B both write addr 0 in the same cycle and hold the request: A=16'h1111, B=16'h2222.
//    - Expect: A granted first and b_waitrequest=1; B granted the next cycle; reg0 ends at 16'h2222.
//    - A repeat contention grants A again.
// 3. Partial write
//    - A writes 16'hABCD with be=2'b01 over reg2=16'h1234.
//    - Expect: reg_byteenable=2'b01; reg2=16'h12CD.
// 4. Read and write together
//    - A asserts read and write together, writing 16'h5A5A to addr 3.
//    - Expect: reg_write=1; a_readdatavalid never pulses; a later read returns 16'h5A5A.
// 5. Reset during a read
//    - Assert reset in the cycle a B read is granted.
//    - Expect: b_readdatavalid=0 the next cycle; readdata=0.
// 6. Lock timeout (ARB_LOCK_EN, LOCK_MAX=16)
//    - A holds a_lock for 20 cycles; B requests continuously.
//    - Expect: b_waitrequest high for 16 lock cycles after A's locking grant; B granted on the cycle after forced release.
//    - A does not re-lock until a_lock has dropped.

Source files
------------

// File: rtl/reg16_port_arbiter.sv
// reg16_port_arbiter
// Two-master Avalon-MM round-robin arbiter in front of a single-port bank of
// 16-bit registers. Writes reach the bank in the granted cycle. Reads return
// one cycle later on the winning port's readdata/readdatavalid.
// Optional feature: define ARB_LOCK_EN to add a_lock/b_lock grant locking
// with a forced release after LOCK_MAX locked cycles.
module reg16_port_arbiter #(
    parameter int ADDR_W   = 2,
    parameter int LOCK_MAX = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_chipselect,
    input  logic              a_read,
    input  logic              a_write,
    input  logic [ADDR_W-1:0] a_address,
    input  logic [1:0]        a_byteenable,
    input  logic [15:0]       a_writedata,
    output logic              a_waitrequest,
    output logic [15:0]       a_readdata,
    output logic              a_readdatavalid,
    input  logic              b_chipselect,
    input  logic              b_read,
    input  logic              b_write,
    input  logic [ADDR_W-1:0] b_address,
    input  logic [1:0]        b_byteenable,
    input  logic [15:0]       b_writedata,
    output logic              b_waitrequest,
    output logic [15:0]       b_readdata,
    output logic              b_readdatavalid,
`ifdef ARB_LOCK_EN
    input  logic              a_lock,
    input  logic              b_lock,
`endif
    output logic [ADDR_W-1:0] reg_address,
    output logic [1:0]        reg_byteenable,
    output logic [15:0]       reg_writedata,
    output logic              reg_write,
    input  logic [15:0]       reg_readdata
);

    logic req_a;
    logic req_b;
    logic grant_a;
    logic grant_b;
    logic last_grant_b;

    assign req_a = a_chipselect & (a_read | a_write);
    assign req_b = b_chipselect & (b_read | b_write);

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } lock_state_t;

    localparam int CNT_W = $clog2(LOCK_MAX + 1);

    lock_state_t      state;
    lock_state_t      state_next;
    logic [CNT_W-1:0] lock_cnt;
    logic [CNT_W-1:0] lock_cnt_next;
    logic [CNT_W-1:0] lock_cnt_inc;
    logic             block_a;
    logic             block_b;
    logic             block_a_next;
    logic             block_b_next;
    logic             exit_a;
    logic             exit_b;
`else
    logic unused_lock_max;
    assign unused_lock_max = (LOCK_MAX >= 1);
`endif

    // Pick at most one winner per cycle; a held lock excludes the other port,
    // and nobody is granted while reset is high so waitrequest mirrors req.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
`ifdef ARB_LOCK_EN
            if (state == LOCK_A) begin
                grant_a = req_a;
            end else if (state == LOCK_B) begin
                grant_b = req_b;
            end else begin
`else
            begin
`endif
                if (req_a && req_b) begin
                    grant_a = last_grant_b;
                    grant_b = ~last_grant_b;
                end else begin
                    grant_a = req_a;
                    grant_b = req_b;
                end
            end
        end
    end

    assign a_waitrequest = req_a & ~grant_a;
    assign b_waitrequest = req_b & ~grant_b;

    // Steer the winner onto the bank; byte lanes and the strobe only for writes.
    always_comb begin
        reg_address    = '0;
        reg_byteenable = 2'b00;
        reg_writedata  = 16'h0000;
        reg_write      = 1'b0;
        if (grant_a) begin
            reg_address = a_address;
            if (a_write) begin
                reg_write      = 1'b1;
                reg_byteenable = a_byteenable;
                reg_writedata  = a_writedata;
            end
        end else if (grant_b) begin
            reg_address = b_address;
            if (b_write) begin
                reg_write      = 1'b1;
                reg_byteenable = b_byteenable;
                reg_writedata  = b_writedata;
            end
        end
    end

    // Capture read data for granted pure reads and remember who went last.
    always_ff @(posedge clock) begin
        if (reset) begin
            a_readdata      <= 16'h0000;
            a_readdatavalid <= 1'b0;
            b_readdata      <= 16'h0000;
            b_readdatavalid <= 1'b0;
            last_grant_b    <= 1'b1;
        end else begin
            a_readdatavalid <= grant_a & a_read & ~a_write;
            b_readdatavalid <= grant_b & b_read & ~b_write;
            if (grant_a && a_read && !a_write) begin
                a_readdata <= reg_readdata;
            end
            if (grant_b && b_read && !b_write) begin
                b_readdata <= reg_readdata;
            end
            if (grant_a) begin
                last_grant_b <= 1'b0;
            end else if (grant_b) begin
                last_grant_b <= 1'b1;
            end
`ifdef ARB_LOCK_EN
            if (exit_a) begin
                last_grant_b <= 1'b0;
            end else if (exit_b) begin
                last_grant_b <= 1'b1;
            end
`endif
        end
    end

`ifdef ARB_LOCK_EN
    // Lock state, hold counter and the re-lock blockers after a forced release.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            lock_cnt <= '0;
            block_a  <= 1'b0;
            block_b  <= 1'b0;
        end else begin
            state    <= state_next;
            lock_cnt <= lock_cnt_next;
            block_a  <= block_a_next;
            block_b  <= block_b_next;
        end
    end

    // Enter a lock on a locking grant; leave on lock drop or when the hold limit is hit.
    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        lock_cnt_inc  = lock_cnt + CNT_W'(1);
        exit_a        = 1'b0;
        exit_b        = 1'b0;
        block_a_next  = block_a & a_lock;
        block_b_next  = block_b & b_lock;
        case (state)
            IDLE: begin
                lock_cnt_next = '0;
                if (grant_a && a_lock && !block_a) begin
                    state_next = LOCK_A;
                end else if (grant_b && b_lock && !block_b) begin
                    state_next = LOCK_B;
                end
            end
            LOCK_A: begin
                if (!a_lock) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    exit_a        = 1'b1;
                end else if (lock_cnt_inc == CNT_W'(LOCK_MAX)) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    exit_a        = 1'b1;
                    block_a_next  = 1'b1;
                end else begin
                    lock_cnt_next = lock_cnt_inc;
                end
            end
            LOCK_B: begin
                if (!b_lock) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    exit_b        = 1'b1;
                end else if (lock_cnt_inc == CNT_W'(LOCK_MAX)) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    exit_b        = 1'b1;
                    block_b_next  = 1'b1;
                end else begin
                    lock_cnt_next = lock_cnt_inc;
                end
            end
            default: begin
                state_next    = IDLE;
                lock_cnt_next = '0;
            end
        endcase
    end
`endif

endmodule
